lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Load/store sequencer between the core's memory stage and the word-wide, single-port data memory. The memory has a 1-cycle registered read, is word-indexed and supports write-or-read only.
- Accepts byte, halfword and word requests over a valid/ready handshake.
- Handles loads with lane extraction and sign or zero extension.
- Sequences sub-word stores as read-modify-write.
- Returns a one-cycle response pulse per request.

Parameters:
- MEM_AW, 12, word-address bits driven to the memory; upper mem_addr_o bits are zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend loads (LBU/LHU)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  load result (0 for stores)
- rsp_err_o  out  1  misaligned or illegal request
- mem_write_o  out  1  memory write enable
- mem_addr_o  out  32  word address = {zeros, req_addr_i[MEM_AW+1:2]}
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data, valid the cycle after the address is presented with mem_write_o=0

Behaviour:
Reset:
- State IDLE.
- req_ready_o=0; it is registered and rises on the first edge after reset release.
- All other outputs are 0.

Handshake:
- A request is accepted on an edge where req_valid_i & req_ready_o.
- All request fields are latched at accept; inputs are ignored afterwards.
- req_ready_o falls on the accept edge and rises on the edge that returns to IDLE, coincident with rsp_valid_o. Back-to-back requests are therefore allowed.
- There is no response backpressure.

FSM states: IDLE, LD_ADDR, LD_DATA, ST_WR, RMW_RD, RMW_MRG, RMW_WR, ERR. All memory outputs are registered.
- Load: accept -> LD_ADDR (mem_write_o=0, mem_addr_o set) -> LD_DATA (sample mem_rdata_i) -> IDLE. rsp_valid_o is high 2 cycles after accept.
- Word store: accept -> ST_WR (mem_write_o=1, mem_wdata_o=req_wdata_i) -> IDLE. rsp_valid_o is high 1 cycle after accept.
- Byte/half store: accept -> RMW_RD -> RMW_MRG (merge new lanes into mem_rdata_i) -> RMW_WR (mem_write_o=1, merged word) -> IDLE. rsp_valid_o is high 3 cycles after accept.
- mem_write_o is high for exactly one cycle per store. It is 0 in every other state.

Lanes (little-endian):
- Byte k = bits [8k+7:8k], k = addr[1:0].
- Half j = bits [16j+15:16j], j = addr[1].

Load result:
- The selected lane is sign-extended, or zero-extended when req_unsigned_i=1.
- Word loads ignore req_unsigned_i.

Response contents:
- rsp_rdata_o holds the result only during the rsp_valid_o cycle and is 0 otherwise.
- Stores return rsp_rdata_o=0.

Reset mid-operation:
- Abort immediately; no response is issued.
- If the controller is in RMW_RD/RMW_MRG, no memory write occurs.
- mem_write_o drops asynchronously.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Illegal requests are halfword with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - An illegal request goes accept -> ERR -> IDLE: rsp_valid_o=1 and rsp_err_o=1 one cycle after accept, rsp_rdata_o=0.
  - No memory access of any kind occurs (mem_write_o stays 0).
- Undefined:
  - rsp_err_o is tied 0.
  - Halfword ignores addr[0]; word ignores addr[1:0]; size 11 is treated as word.

Test Plan:
1. SW 0xDEADBEEF @0x10, then LW @0x10 -> one mem_write_o pulse with mem_addr_o=4; load rsp_rdata_o=0xDEADBEEF 2 cycles after accept.
2. Word 0x80FF7F01 @0x20; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
3. Word 0x11223344 @0x30; SB 0xAA @0x31 -> RMW writes 0x1122AA44, rsp 3 cycles after accept; then SH 0xBEEF @0x32 -> word reads back 0xBEEFAA44.
4. Back-to-back: req_valid_i held high for SW then LW to the same address -> second request accepted on the rsp_valid_o cycle of the first; the load returns the new data.
5. With LSU_MISALIGN_TRAP_EN defined, LW @0x02 -> rsp_err_o=1 one cycle after accept, no mem_write_o. Without the macro, same request -> reads word @0x00, rsp_err_o=0.
6. Assert rst_ni low during RMW_MRG of SB @0x31 -> no write, no rsp_valid_o; memory word unchanged; req_ready_o=1 one edge after release.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Request/response and data-memory signal bundle for lsu_ctrl.
// slave = the controller; master = core plus memory environment.
interface lsu_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for a word-wide single-port memory with 1-cycle registered read.
// Optional misalignment/illegal-size trapping: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int MEM_AW = 12
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lsu_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_ADDR = 3'd1;
  localparam logic [2:0] LD_DATA = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] RMW_RD  = 3'd4;
  localparam logic [2:0] RMW_MRG = 3'd5;
  localparam logic [2:0] RMW_WR  = 3'd6;
  localparam logic [2:0] ERR     = 3'd7;

  logic [2:0]  state_q;
  logic        ready_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        req_illegal;
  logic [31:0] req_word_addr;
  logic        unused_addr_bits;

  assign accept = bus.req_valid_i & ready_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_word_addr = '0;
    req_word_addr[MEM_AW-1:0] = bus.req_addr_i[MEM_AW+1:2];
  end
  assign unused_addr_bits = ^bus.req_addr_i[31:MEM_AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_illegal = (bus.req_size_i == 2'b11) ||
                       (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                       (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
  assign bus.rsp_err_o = rsp_err_q;
`else
  assign req_illegal   = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  // Size 11 decodes as word (size[1] set); halfword lane comes from off[1] only.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    if (size[1])            return w;
    else if (size == 2'b01) return {{16{~uns & h[15]}}, h};
    else                    return {{24{~uns & b[7]}}, b};
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] m;
    m = old;
    if (size == 2'b01) m[{off[1], 4'b0000} +: 16] = wd[15:0];
    else               m[{off, 3'b000} +: 8]      = wd[7:0];
    return m;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Response and write strobe are single-cycle pulses unless a state re-asserts them.
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_write_q <= 1'b0;

      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            size_q  <= bus.req_size_i;
            uns_q   <= bus.req_unsigned_i;
            off_q   <= bus.req_addr_i[1:0];
            wdata_q <= bus.req_wdata_i;
            if (req_illegal) begin
              state_q <= ERR;
            end else if (!bus.req_we_i) begin
              state_q    <= LD_ADDR;
              mem_addr_q <= req_word_addr;
            end else if (bus.req_size_i[1]) begin
              state_q     <= ST_WR;
              mem_addr_q  <= req_word_addr;
              mem_wdata_q <= bus.req_wdata_i;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= RMW_RD;
              mem_addr_q <= req_word_addr;
            end
          end
        end
        LD_ADDR: state_q <= LD_DATA;
        LD_DATA: begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_extract(bus.mem_rdata_i, size_q, uns_q, off_q);
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        RMW_RD: state_q <= RMW_MRG;
        RMW_MRG: begin
          mem_wdata_q <= store_merge(bus.mem_rdata_i, wdata_q, size_q, off_q);
          mem_write_q <= 1'b1;
          state_q     <= RMW_WR;
        end
        ST_WR, RMW_WR: begin
          rsp_valid_q <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        ERR: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.mem_write_o = mem_write_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule
